// File: rtl/card_match_engine.sv
// Memory-card pair matcher: two selections, a one-cycle compare, then match or timed face-up display.
// All outputs are registered; selections are accepted only while sel_ready is high.
module card_match_engine #(
  parameter int HIDE_CYCLES = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        map_load,
  input  logic [47:0] map_in,
  input  logic        sel_valid,
  input  logic [3:0]  sel_idx,
  output logic        sel_ready,
  output logic        sel_reject,
  output logic [15:0] revealed,
  output logic [15:0] matched,
  output logic        result_valid,
  output logic        result_match,
  output logic [7:0]  move_cnt,
  output logic        game_over
);

  typedef enum logic [2:0] {IDLE, WAIT_FIRST, WAIT_SECOND, COMPARE, SHOW, WIN} state_t;

  localparam int CW = (HIDE_CYCLES > 1) ? $clog2(HIDE_CYCLES) : 1;
  localparam logic [CW-1:0] SHOW_LOAD = CW'(HIDE_CYCLES - 1);

  state_t        state_q, state_d;
  logic [47:0]   map_q, map_d;
  logic [3:0]    first_q, first_d;
  logic [3:0]    second_q, second_d;
  logic [15:0]   revealed_q, revealed_d;
  logic [15:0]   matched_q, matched_d;
  logic [7:0]    move_cnt_q, move_cnt_d;
  logic [CW-1:0] show_cnt_q, show_cnt_d;
  logic          result_valid_q, result_valid_d;
  logic          result_match_q, result_match_d;
  logic          sel_reject_q, sel_reject_d;
  logic          sel_ready_q, sel_ready_d;
  logic          game_over_q, game_over_d;

  logic          sel_acc;
  logic          sel_bad;
  logic          sym_eq;
  logic [15:0]   pair_mask;

  always_comb begin
    state_d        = state_q;
    map_d          = map_q;
    first_d        = first_q;
    second_d       = second_q;
    revealed_d     = revealed_q;
    matched_d      = matched_q;
    move_cnt_d     = move_cnt_q;
    show_cnt_d     = show_cnt_q;
    result_valid_d = 1'b0;
    result_match_d = result_match_q;
    sel_reject_d   = 1'b0;

    sel_acc   = sel_valid && sel_ready_q && !map_load;
    sel_bad   = matched_q[sel_idx] || ((state_q == WAIT_SECOND) && (sel_idx == first_q));
    pair_mask = (16'h1 << first_q) | (16'h1 << second_q);
    sym_eq    = (map_q[3*first_q +: 3] == map_q[3*second_q +: 3]);

    if (map_load) begin
      state_d        = WAIT_FIRST;
      map_d          = map_in;
      revealed_d     = '0;
      matched_d      = '0;
      move_cnt_d     = '0;
      show_cnt_d     = '0;
      result_match_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_FIRST, WAIT_SECOND: begin
          if (sel_acc) begin
            if (sel_bad) begin
              sel_reject_d = 1'b1;
            end else begin
              revealed_d = revealed_q | (16'h1 << sel_idx);
              if (state_q == WAIT_FIRST) begin
                first_d = sel_idx;
                state_d = WAIT_SECOND;
              end else begin
                second_d = sel_idx;
                state_d  = COMPARE;
              end
            end
          end
        end
        COMPARE: begin
          result_valid_d = 1'b1;
          result_match_d = sym_eq;
          if (move_cnt_q != 8'hFF) move_cnt_d = move_cnt_q + 8'd1;
          if (sym_eq) begin
            matched_d  = matched_q | pair_mask;
            revealed_d = revealed_q & ~pair_mask;
            state_d    = (matched_d == 16'hFFFF) ? WIN : WAIT_FIRST;
          end else begin
            show_cnt_d = SHOW_LOAD;
            state_d    = SHOW;
          end
        end
        SHOW: begin
          // Counter runs HIDE_CYCLES-1 down to 0, so SHOW lasts exactly HIDE_CYCLES cycles.
          if (show_cnt_q == '0) begin
            revealed_d = revealed_q & ~pair_mask;
            state_d    = WAIT_FIRST;
          end else begin
            show_cnt_d = show_cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end

    sel_ready_d = (state_d == WAIT_FIRST) || (state_d == WAIT_SECOND);
    game_over_d = (state_d == WIN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      map_q          <= '0;
      first_q        <= '0;
      second_q       <= '0;
      revealed_q     <= '0;
      matched_q      <= '0;
      move_cnt_q     <= '0;
      show_cnt_q     <= '0;
      result_valid_q <= 1'b0;
      result_match_q <= 1'b0;
      sel_reject_q   <= 1'b0;
      sel_ready_q    <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      map_q          <= map_d;
      first_q        <= first_d;
      second_q       <= second_d;
      revealed_q     <= revealed_d;
      matched_q      <= matched_d;
      move_cnt_q     <= move_cnt_d;
      show_cnt_q     <= show_cnt_d;
      result_valid_q <= result_valid_d;
      result_match_q <= result_match_d;
      sel_reject_q   <= sel_reject_d;
      sel_ready_q    <= sel_ready_d;
      game_over_q    <= game_over_d;
    end
  end

  assign sel_ready    = sel_ready_q;
  assign sel_reject   = sel_reject_q;
  assign revealed     = revealed_q;
  assign matched      = matched_q;
  assign result_valid = result_valid_q;
  assign result_match = result_match_q;
  assign move_cnt     = move_cnt_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_card_match_engine.sv
// Scoreboard bench for card_match_engine: directed moves queue expected result/reject events,
// a negedge monitor pops and compares them; state outputs are also checked inline.
module tb_card_match_engine;
  localparam int HIDE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        map_load = 1'b0;
  logic [47:0] map_in = '0;
  logic        sel_valid = 1'b0;
  logic [3:0]  sel_idx = '0;
  logic        sel_ready;
  logic        sel_reject;
  logic [15:0] revealed;
  logic [15:0] matched;
  logic        result_valid;
  logic        result_match;
  logic [7:0]  move_cnt;
  logic        game_over;

  typedef struct {
    bit          is_result;
    bit          match;
    logic [7:0]  moves;
    logic [15:0] matched;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [47:0] test_map;

  card_match_engine #(.HIDE_CYCLES(HIDE)) dut (
    .clk(clk), .reset(reset), .map_load(map_load), .map_in(map_in),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .sel_ready(sel_ready),
    .sel_reject(sel_reject), .revealed(revealed), .matched(matched),
    .result_valid(result_valid), .result_match(result_match),
    .move_cnt(move_cnt), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_res(input bit m, input int moves, input logic [15:0] mt);
    exp_t e;
    e.is_result = 1'b1;
    e.match     = m;
    e.moves     = 8'(moves);
    e.matched   = mt;
    exp_q.push_back(e);
  endtask

  task automatic push_rej();
    exp_t e;
    e.is_result = 1'b0;
    e.match     = 1'b0;
    e.moves     = '0;
    e.matched   = '0;
    exp_q.push_back(e);
  endtask

  task automatic sel(input int idx);
    sel_valid = 1'b1;
    sel_idx   = 4'(idx);
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic load();
    map_load = 1'b1;
    map_in   = test_map;
    tick();
    map_load = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (sel_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(name, sel_ready, 1);
  endtask

  // Monitor: every result_valid / sel_reject pulse must match the head of the queue.
  always @(negedge clk) begin
    if (result_valid === 1'b1 || sel_reject === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {30'd0, result_valid, sel_reject}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_kind", result_valid, mon_e.is_result);
        if (mon_e.is_result) begin
          chk("result_match", result_match, mon_e.match);
          chk("result_moves", move_cnt, mon_e.moves);
          chk("result_matched", matched, mon_e.matched);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) test_map[3*i +: 3] = 3'(i >> 1);

    // Reset state
    tick();
    tick();
    chk("rst_sel_ready", sel_ready, 0);
    chk("rst_revealed", revealed, 0);
    chk("rst_matched", matched, 0);
    chk("rst_move_cnt", move_cnt, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_result_match", result_match, 0);
    reset = 1'b1;

    // Selections ignored in IDLE
    sel_valid = 1'b1;
    sel_idx   = 4'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_sel_ready", sel_ready, 0);
      chk("idle_revealed", revealed, 0);
      chk("idle_no_reject", sel_reject, 0);
    end
    sel_valid = 1'b0;

    // First match 0/1
    load();
    chk("load_sel_ready", sel_ready, 1);
    sel(0);
    chk("m01_rev_first", revealed, 16'h0001);
    push_res(1'b1, 1, 16'h0003);
    sel(1);
    chk("m01_rev_second", revealed, 16'h0003);
    chk("m01_compare_not_ready", sel_ready, 0);
    tick();
    chk("m01_result_valid", result_valid, 1);
    chk("m01_revealed", revealed, 0);
    chk("m01_matched", matched, 16'h0003);
    chk("m01_move_cnt", move_cnt, 1);
    chk("m01_ready", sel_ready, 1);

    // Illegal selections
    push_rej();
    sel(1);
    chk("rej_matched_revealed", revealed, 0);
    chk("rej_matched_ready", sel_ready, 1);
    sel(4);
    push_rej();
    sel(4);
    chk("rej_same_revealed", revealed, 16'h0010);
    chk("rej_same_ready", sel_ready, 1);
    chk("rej_same_matched", matched, 16'h0003);
    push_res(1'b1, 2, 16'h0033);
    sel(5);
    chk("m45_rev", revealed, 16'h0030);
    tick();
    chk("m45_revealed", revealed, 0);

    // Mismatch with timed SHOW
    load();
    sel(0);
    push_res(1'b0, 1, 16'h0000);
    sel(2);
    chk("mis_rev_pair", revealed, 16'h0005);
    for (int i = 0; i < HIDE; i++) begin
      tick();
      chk("show_revealed", revealed, 16'h0005);
      chk("show_not_ready", sel_ready, 0);
    end
    tick();
    chk("show_exit_revealed", revealed, 0);
    chk("show_exit_ready", sel_ready, 1);
    chk("show_exit_moves", move_cnt, 1);
    chk("show_exit_result_match", result_match, 0);

    // Full game to WIN
    load();
    for (int p = 0; p < 8; p++) begin
      push_res(1'b1, p + 1, 16'((32'h1 << (2*p + 2)) - 1));
      sel(2*p);
      sel(2*p + 1);
      tick();
    end
    chk("win_matched", matched, 16'hFFFF);
    chk("win_moves", move_cnt, 8);
    chk("win_game_over", game_over, 1);
    chk("win_ready", sel_ready, 0);
    chk("win_revealed", revealed, 0);
    sel(3);
    chk("win_hold", game_over, 1);
    load();
    chk("reload_matched", matched, 0);
    chk("reload_moves", move_cnt, 0);
    chk("reload_game_over", game_over, 0);
    chk("reload_ready", sel_ready, 1);
    chk("reload_result_match", result_match, 0);

    // map_load during SHOW
    sel(0);
    push_res(1'b0, 1, 16'h0000);
    sel(2);
    tick();
    tick();
    load();
    chk("ld_show_revealed", revealed, 0);
    chk("ld_show_ready", sel_ready, 1);
    chk("ld_show_moves", move_cnt, 0);
    repeat (6) tick();
    chk("ld_show_stable_rev", revealed, 0);
    chk("ld_show_stable_ready", sel_ready, 1);

    // Reset during WAIT_SECOND
    push_res(1'b1, 1, 16'h0003);
    sel(0);
    sel(1);
    tick();
    sel(6);
    chk("ws_revealed", revealed, 16'h0040);
    reset = 1'b0;
    sel_valid = 1'b1;
    sel_idx = 4'd7;
    tick();
    sel_valid = 1'b0;
    reset = 1'b1;
    chk("rst_ws_revealed", revealed, 0);
    chk("rst_ws_matched", matched, 0);
    chk("rst_ws_moves", move_cnt, 0);
    chk("rst_ws_ready", sel_ready, 0);
    chk("rst_ws_result_match", result_match, 0);

    // Move counter saturation
    load();
    for (int n = 1; n <= 260; n++) begin
      push_res(1'b0, (n > 255) ? 255 : n, 16'h0000);
      sel(0);
      sel(2);
      wait_ready("sat_ready_timeout");
    end
    chk("sat_move_cnt", move_cnt, 255);

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
